// File: rtl/neuron_weight_update.sv
// neuron_weight_update: serial delta-rule weight update w <- w - lr*err*x over N inputs plus bias.
// Define NEURON_WEIGHT_UPDATE_SAT_EN to saturate results; otherwise they wrap to W bits.
module neuron_weight_update #(
    parameter int N    = 32,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         err,
    input  logic [W-1:0]         lr,
    input  logic [N*W-1:0]       dendrites,
    input  logic [N-1:0]         enabled,
    input  logic [(N+1)*W-1:0]   weights_in,
    output logic [(N+1)*W-1:0]   weights_out,
    output logic                 busy,
    output logic                 done
);
    localparam int IW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic signed [W-1:0] err_q, lr_q, x, w, r_w;
    logic [N*W-1:0] x_q;
    logic [N-1:0] en_q;
    logic [(N+1)*W-1:0] w_q, x_ext;
    logic [N:0] en_ext;
    logic en, last;
    logic signed [2*W-1:0] p1, s1;
    logic signed [3*W-1:0] p2, s2;
    logic signed [3*W:0] r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE)   ? (start ? UPDATE : IDLE) :
                   (state == UPDATE) ? (last ? DONE : UPDATE) : IDLE;
    end
    always_comb begin
        busy = (state == UPDATE);
        done = (state == DONE);
    end
    // The bias is an always-enabled input fixed at 1.0, appended above the dendrites.
    always_comb begin
        last   = (idx == IW'(N));
        x_ext  = {W'(1 << FRAC), x_q};
        en_ext = {1'b1, en_q};
        x      = x_ext[int'(idx)*W +: W];
        w      = w_q[int'(idx)*W +: W];
        en     = en_ext[idx];
        p1     = (2*W)'(err_q) * (2*W)'(x);
        s1     = p1 >>> FRAC;
        p2     = (3*W)'(s1) * (3*W)'(lr_q);
        s2     = p2 >>> FRAC;
        r      = (3*W+1)'(w) - (3*W+1)'(s2);
    end
`ifdef NEURON_WEIGHT_UPDATE_SAT_EN
    always_comb begin
        r_w = (&r[3*W:W-1] | ~|r[3*W:W-1]) ? r[W-1:0] :
              (r[3*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
    end
`else
    logic unused_hi;
    always_comb begin
        r_w       = r[W-1:0];
        unused_hi = ^r[3*W:W];
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            err_q       <= '0;
            lr_q        <= '0;
            x_q         <= '0;
            en_q        <= '0;
            w_q         <= '0;
            weights_out <= '0;
        end else if (state == IDLE && start) begin
            idx         <= '0;
            err_q       <= err;
            lr_q        <= lr;
            x_q         <= dendrites;
            en_q        <= enabled;
            w_q         <= weights_in;
            weights_out <= weights_in;
        end else if (state == UPDATE) begin
            if (en) weights_out[int'(idx)*W +: W] <= r_w;
            idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_neuron_weight_update.sv
// tb_neuron_weight_update: directed checks of the delta-rule weight updater (N=32, W=16, FRAC=8).
module tb_neuron_weight_update;
    localparam int N = 32;
    localparam int W = 16;
    localparam int FRAC = 8;
    logic clk = 0, rst = 1, start = 0;
    logic [W-1:0] err, lr;
    logic [N*W-1:0] dendrites;
    logic [N-1:0] enabled;
    logic [(N+1)*W-1:0] weights_in, weights_out;
    logic busy, done;
    int n_cmp = 0, n_bad = 0;

    neuron_weight_update #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .err(err), .lr(lr),
        .dendrites(dendrites), .enabled(enabled), .weights_in(weights_in),
        .weights_out(weights_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic set_ops(input logic [W-1:0] e, input logic [W-1:0] l, input logic [W-1:0] d,
                           input logic [N-1:0] m, input logic [W-1:0] w0);
        err = e;
        lr = l;
        enabled = m;
        for (int i = 0; i < N; i++) dendrites[i*W +: W] = d;
        for (int i = 0; i <= N; i++) weights_in[i*W +: W] = w0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
    endtask

    task automatic test_reset();
        set_ops(16'h0100, 16'h0100, 16'h0200, '1, 16'h0100);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++;
        if (weights_out !== '0) begin n_bad++; $display("FAIL reset_weights: got %h expected 0", weights_out); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic();
        int nb = 0, dc = 0, dl = -1;
        logic [W-1:0] exp;
        set_ops(16'h0100, 16'h0100, 16'h0200, '1, 16'h0000);
        pulse_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin dc++; dl = k; end
        end
        n_cmp++;
        if (nb != N + 1) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected %0d", nb, N + 1); end
        n_cmp++;
        if (dc != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", dc); end
        n_cmp++;
        if (dl != N + 2) begin n_bad++; $display("FAIL basic_done_latency: got %0d expected %0d", dl, N + 2); end
        for (int i = 0; i <= N; i++) begin
            exp = (i == N) ? 16'hFF00 : 16'hFE00;
            n_cmp++;
            if (weights_out[i*W +: W] !== exp) begin
                n_bad++;
                $display("FAIL basic_w[%0d]: got %h expected %h", i, weights_out[i*W +: W], exp);
            end
        end
    endtask

    task automatic test_enable_mask();
        bit seen;
        logic [W-1:0] exp;
        set_ops(16'h0100, 16'h0100, 16'h0200, 32'h0000FFFF, 16'h0100);
        pulse_start();
        wait_done(seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL mask_done_timeout: got no done expected done"); end
        for (int i = 0; i <= N; i++) begin
            exp = (i == N) ? 16'h0000 : (i < 16) ? 16'hFF00 : 16'h0100;
            n_cmp++;
            if (weights_out[i*W +: W] !== exp) begin
                n_bad++;
                $display("FAIL mask_w[%0d]: got %h expected %h", i, weights_out[i*W +: W], exp);
            end
        end
    endtask

    task automatic test_overflow();
        bit seen;
        logic [W-1:0] exp0;
`ifdef NEURON_WEIGHT_UPDATE_SAT_EN
        exp0 = 16'h8000;
`else
        exp0 = 16'h0400;
`endif
        set_ops(16'h0100, 16'h0100, 16'h0000, '1, 16'h0000);
        dendrites[0 +: W] = 16'h7F00;
        weights_in[0 +: W] = 16'h8300;
        pulse_start();
        wait_done(seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL ovf_done_timeout: got no done expected done"); end
        n_cmp++;
        if (weights_out[0 +: W] !== exp0) begin n_bad++; $display("FAIL ovf_w0: got %h expected %h", weights_out[0 +: W], exp0); end
        n_cmp++;
        if (weights_out[W +: W] !== 16'h0000) begin n_bad++; $display("FAIL ovf_w1: got %h expected 0000", weights_out[W +: W]); end
        n_cmp++;
        if (weights_out[N*W +: W] !== 16'hFF00) begin n_bad++; $display("FAIL ovf_bias: got %h expected ff00", weights_out[N*W +: W]); end
    endtask

    task automatic test_negative();
        bit seen;
        set_ops(16'hFF80, 16'h0080, 16'h0100, '1, 16'h0000);
        dendrites[W +: W] = 16'h0001;
        pulse_start();
        wait_done(seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL neg_done_timeout: got no done expected done"); end
        n_cmp++;
        if (weights_out[0 +: W] !== 16'h0040) begin n_bad++; $display("FAIL neg_w0: got %h expected 0040", weights_out[0 +: W]); end
        n_cmp++;
        if (weights_out[W +: W] !== 16'h0001) begin n_bad++; $display("FAIL neg_floor_w1: got %h expected 0001", weights_out[W +: W]); end
        n_cmp++;
        if (weights_out[5*W +: W] !== 16'h0040) begin n_bad++; $display("FAIL neg_w5: got %h expected 0040", weights_out[5*W +: W]); end
        n_cmp++;
        if (weights_out[N*W +: W] !== 16'h0040) begin n_bad++; $display("FAIL neg_bias: got %h expected 0040", weights_out[N*W +: W]); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dc = 0;
        set_ops(16'h0100, 16'h0100, 16'h0200, '1, 16'h0000);
        pulse_start();
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_cmp++;
        if (weights_out !== '0) begin n_bad++; $display("FAIL midrst_weights: got %h expected 0", weights_out); end
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        n_cmp++;
        if (dc != 0) begin n_bad++; $display("FAIL midrst_stray_done: got %0d expected 0", dc); end
        pulse_start();
        wait_done(seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL midrst_repass_timeout: got no done expected done"); end
        n_cmp++;
        if (weights_out[7*W +: W] !== 16'hFE00) begin n_bad++; $display("FAIL midrst_repass_w7: got %h expected fe00", weights_out[7*W +: W]); end
        n_cmp++;
        if (weights_out[N*W +: W] !== 16'hFF00) begin n_bad++; $display("FAIL midrst_repass_bias: got %h expected ff00", weights_out[N*W +: W]); end
    endtask

    task automatic test_back_to_back();
        int dc = 0, t1 = -1, t2 = -1;
        set_ops(16'h0100, 16'h0100, 16'h0200, '1, 16'h0000);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 set_ops(16'h0100, 16'h0100, 16'h0200, 32'h0000FFFF, 16'h0100);
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                if (dc == 1) begin
                    t1 = k;
                    n_cmp++;
                    if (weights_out[20*W +: W] !== 16'hFE00) begin n_bad++; $display("FAIL b2b_p1_w20: got %h expected fe00", weights_out[20*W +: W]); end
                    n_cmp++;
                    if (weights_out[N*W +: W] !== 16'hFF00) begin n_bad++; $display("FAIL b2b_p1_bias: got %h expected ff00", weights_out[N*W +: W]); end
                end else if (dc == 2) begin
                    t2 = k;
                    start = 0;
                    n_cmp++;
                    if (weights_out[0 +: W] !== 16'hFF00) begin n_bad++; $display("FAIL b2b_p2_w0: got %h expected ff00", weights_out[0 +: W]); end
                    n_cmp++;
                    if (weights_out[20*W +: W] !== 16'h0100) begin n_bad++; $display("FAIL b2b_p2_w20: got %h expected 0100", weights_out[20*W +: W]); end
                    n_cmp++;
                    if (weights_out[N*W +: W] !== 16'h0000) begin n_bad++; $display("FAIL b2b_p2_bias: got %h expected 0000", weights_out[N*W +: W]); end
                end
            end
        end
        start = 0;
        n_cmp++;
        if (dc != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", dc); end
        n_cmp++;
        if (t1 != N + 2) begin n_bad++; $display("FAIL b2b_first_done: got %0d expected %0d", t1, N + 2); end
        n_cmp++;
        if (t2 != 2*N + 5) begin n_bad++; $display("FAIL b2b_second_done: got %0d expected %0d", t2, 2*N + 5); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_mask();
        test_overflow();
        test_negative();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
